// File: rtl/datapath_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// datapath_seq_pkg
// Shared constants and helpers for the datapath sequencer: the state-code
// enumeration, the fixed sequence order table, and index/next-code lookups.
// Optional build macro used by the sequencer: SEQ_SINGLE_STEP_EN.
// -----------------------------------------------------------------------------
package datapath_seq_pkg;

    localparam int unsigned STEP_W  = 4;
    localparam int unsigned SEQ_LEN = 14;

    localparam logic [3:0] IDLE_CODE    = 4'd0;
    localparam logic [3:0] DONE_CODE    = 4'd11;
    localparam logic [3:0] ILLEGAL_CODE_A = 4'd12;
    localparam logic [3:0] ILLEGAL_CODE_B = 4'd13;

    // Enumerators carry the exact S codes seen by the control-output decoder.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_C1   = 4'd1,
        ST_C2   = 4'd2,
        ST_C3   = 4'd3,
        ST_C4   = 4'd4,
        ST_C5   = 4'd5,
        ST_C6   = 4'd6,
        ST_C7   = 4'd7,
        ST_C8   = 4'd15,
        ST_C9   = 4'd14,
        ST_C10  = 4'd8,
        ST_C11  = 4'd9,
        ST_C12  = 4'd10,
        ST_DONE = 4'd11
    } state_t;

    localparam logic [3:0] SEQ_ORDER [SEQ_LEN] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
        4'd7, 4'd15, 4'd14, 4'd8, 4'd9, 4'd10, 4'd11
    };

    function automatic logic is_legal(input logic [3:0] code);
        return (code != ILLEGAL_CODE_A) && (code != ILLEGAL_CODE_B);
    endfunction

    // Position of a code in SEQ_ORDER; illegal codes map to 0.
    function automatic logic [STEP_W-1:0] step_of(input logic [3:0] code);
        logic [STEP_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            if (SEQ_ORDER[i] == code) idx = STEP_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] next_code(input logic [3:0] code);
        int unsigned idx;
        idx = int'(step_of(code));
        if (idx < SEQ_LEN - 1) return SEQ_ORDER[idx + 1];
        return IDLE_CODE;
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// -----------------------------------------------------------------------------
// datapath_sequencer_if
// Host/decoder-facing signals of the datapath sequencer.
//   start, stall, abort, done_ack  host controls into the sequencer
//   step_pulse                     single-step advance (SEQ_SINGLE_STEP_EN only)
//   S, step_idx                    state code and sequence position
//   busy, seq_done, err            status outputs
// master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface datapath_sequencer_if;
    logic       start;
    logic       stall;
    logic       abort;
    logic       done_ack;
`ifdef SEQ_SINGLE_STEP_EN
    logic       step_pulse;
`endif
    logic [3:0] S;
    logic       busy;
    logic       seq_done;
    logic [3:0] step_idx;
    logic       err;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        output step_pulse,
`endif
        output start, stall, abort, done_ack,
        input  S, busy, seq_done, step_idx, err
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        input  step_pulse,
`endif
        input  start, stall, abort, done_ack,
        output S, busy, seq_done, step_idx, err
    );
endinterface

// File: rtl/datapath_sequencer_dwell.sv
// -----------------------------------------------------------------------------
// seq_dwell_counter
// Saturating up-counter that measures how long a state has been occupied.
//   clk, rst     clock / async active-high reset
//   i_clear      synchronous clear to zero (highest priority)
//   i_load       synchronous load of i_load_val
//   i_en         count up by one (stops once expired)
//   i_limit      terminal count
//   o_expired    count has reached i_limit
// -----------------------------------------------------------------------------
module seq_dwell_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);
    logic [WIDTH-1:0] r_count;

    assign o_expired = (r_count >= i_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Control FSM producing the 4-bit state code S for the datapath control-output
// decoder. One fixed 12-step computation per accepted start, with stall,
// abort, done-acknowledge handshake and illegal-code recovery.
//   clk, rst   clock / async active-high reset
//   bus        datapath_sequencer_if.slave (start, stall, abort, done_ack,
//              S, busy, seq_done, step_idx, err [, step_pulse])
// Parameters: STEP_CYCLES (cycles per compute step, 1..15),
//             DONE_HOLD_MIN (min DONE cycles before done_ack honoured, 0..15).
// Build macro SEQ_SINGLE_STEP_EN: compute steps advance only on step_pulse.
// -----------------------------------------------------------------------------
module datapath_sequencer #(
    parameter int unsigned STEP_CYCLES   = 1,
    parameter int unsigned DONE_HOLD_MIN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    datapath_sequencer_if.slave    bus
);
    import datapath_seq_pkg::*;

    localparam logic [3:0] STEP_LIMIT = 4'(STEP_CYCLES - 1);
    // DONE may exit after its own cycle count reaches DONE_HOLD_MIN, i.e.
    // when the dwell count (0-based) has reached DONE_HOLD_MIN-1.
    localparam logic [3:0] HOLD_LIMIT = (DONE_HOLD_MIN == 0) ? 4'd0 : 4'(DONE_HOLD_MIN - 1);

    state_t     r_state;
    logic       r_err;
    state_t     w_next_state;
    logic       w_err_next;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic [3:0] w_limit;
    logic       w_expired;
    logic       w_advance_ok;

`ifdef SEQ_SINGLE_STEP_EN
    assign w_advance_ok = bus.step_pulse;
`else
    assign w_advance_ok = 1'b1;
`endif

    assign w_limit = (r_state == ST_DONE) ? HOLD_LIMIT : STEP_LIMIT;

    seq_dwell_counter #(.WIDTH(4)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (w_cnt_en),
        .i_limit    (w_limit),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_err_next   = r_err;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        if (bus.abort) begin
            w_next_state = ST_IDLE;
            w_cnt_clr    = 1'b1;
        end else if (!is_legal(r_state)) begin
            // Recovery from an upset code is not blocked by stall.
            w_next_state = ST_IDLE;
            w_err_next   = 1'b1;
            w_cnt_clr    = 1'b1;
        end else if (!bus.stall) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_next_state = ST_C1;
                        w_err_next   = 1'b0;
                        w_cnt_clr    = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (w_expired && bus.done_ack) begin
                        w_next_state = ST_IDLE;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
                default: begin
                    if (w_expired && w_advance_ok) begin
                        w_next_state = state_t'(next_code(r_state));
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_en = 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.S        = r_state;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.seq_done = (r_state == ST_DONE);
    assign bus.step_idx = step_of(r_state);
    assign bus.err      = r_err;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Control FSM that generates the 4-bit state code S consumed by the datapath control-output decoder (register enables, tri-state selects, AU opcodes, done).
- Runs one fixed computation sequence per start request.
- Provides a start/done-acknowledge handshake with the host, a stall input, abort and illegal-state recovery.
- Sits between the host controller and the control-output decoder; the decoder stays purely combinational on S.

Parameters:
- STEP_CYCLES, 1, clock cycles spent in each compute state before advancing (1..15); allows multi-cycle AU operations.
- DONE_HOLD_MIN, 0, minimum cycles DONE is held before done_ack is honoured (0..15).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  level; sampled only in IDLE
- stall  input  1  freezes the sequence (no state or dwell change) while high
- abort  input  1  synchronous abort; returns to IDLE next cycle
- done_ack  input  1  host acknowledge of completion
- S  output  4  registered state code to the control-output decoder
- busy  output  1  high in any state other than IDLE
- seq_done  output  1  registered; high while in DONE
- step_idx  output  4  position in the sequence, 0 = IDLE, 13 = DONE
- err  output  1  sticky illegal-state flag; cleared only by rst or start accepted in IDLE

Behaviour:
- Reset (async, rst=1): S=4'd0, step_idx=0, busy=0, seq_done=0, err=0, dwell counter=0. Outputs are valid immediately.
- Sequence order is a constant table SEQ_ORDER:
  - step 0..13 → S = 0,1,2,3,4,5,6,7,15,14,8,9,10,11
  - step 0 (S=0) is IDLE; step 13 (S=11) is DONE.
- Codes 12 and 13 are illegal.
- IDLE: holds while start=0. On start=1 and stall=0, next cycle goes to step 1; err clears.
- Compute steps 1..12:
  - The dwell counter counts to STEP_CYCLES-1, then advances to the next step and resets.
  - With STEP_CYCLES=1, advances every cycle.
  - Latency start→DONE = 12*STEP_CYCLES+1 cycles.
- DONE:
  - seq_done=1.
  - Once held ≥ DONE_HOLD_MIN cycles and done_ack=1, next state is IDLE.
  - done_ack outside DONE is ignored.
- stall=1: S, step_idx and the dwell counter all freeze. stall has priority over advance, start and done_ack.
- abort=1: next state is IDLE and the dwell counter clears, from any state. Priority: rst > abort > stall > normal.
- Illegal S (12 or 13, e.g. after an upset): next cycle goes to IDLE and sets err=1.
- busy and seq_done are decoded from the registered state; no combinational path from inputs to outputs.
- start held high through DONE→IDLE is re-sampled in IDLE, so back-to-back runs have exactly one IDLE cycle between them.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN
- When defined:
  - Adds input step_pulse (1 bit).
  - Compute steps advance only on a cycle where step_pulse=1 and the dwell count has expired. The pulse is ignored otherwise.
  - IDLE/DONE handshake is unchanged.
- When undefined: the port is absent and free-running behaviour applies.

Decomposition:
- Package datapath_seq_pkg holds:
  - SEQ_ORDER constant array (14 × 4 bits)
  - IDLE_CODE=4'd0, DONE_CODE=4'd11, ILLEGAL codes
  - step_idx width constant
- Sub-module seq_dwell_counter: load/clear/enable/expired. It is reused later for AU multi-cycle timing.

Test Plan:
- Reset mid-run: rst pulses at step 5 → S=0, busy=0, err=0 immediately, before the next clk edge.
- Basic run (STEP_CYCLES=1): start=1 for 1 cycle → S sequence 1,2,3,4,5,6,7,15,14,8,9,10,11 on consecutive cycles; seq_done=1 at cycle 13; done_ack → S=0 next cycle.
- STEP_CYCLES=3 with stall: stall held for 4 cycles at step 4 after 1 dwell cycle → S stays 4 for 7 cycles total; DONE reached at cycle 41.
- Abort: abort=1 while S=15 → S=0 next cycle; busy=0; err stays 0.
- Illegal state: force S=12 → next cycle S=0 and err=1; err clears on the next accepted start.
- DONE_HOLD_MIN=2: done_ack=1 on the first DONE cycle → state stays DONE for 2 cycles, then goes to IDLE. start held high → step 1 follows exactly one IDLE cycle later.
